// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
// APB completer with a small bank of 32-bit registers, fixed wait states and
// error signalling. Register 0 is a read-only ID word; registers 1..NUM_REGS-1
// are read/write and clear on reset.
//
// Handshake: a transfer starts when this slave's select bit is high with
// Penable low (setup phase). The following access phase holds select and
// Penable high; Pready rises after WAIT_CYCLES low cycles and the transfer
// completes on the rising edge where Pready is high. Dropping select during
// the access phase abandons the transfer without side effects.
//
// Ports:
//   Hclk        in   system clock, rising edge
//   Hresetn     in   asynchronous active-low reset
//   Pselx[2:0]  in   one-hot slave select, bit SLV_INDEX selects this slave
//   Penable     in   access-phase marker
//   Pwrite      in   1 = write, 0 = read
//   Paddr[31:0] in   byte address, word index in Paddr[5:2]
//   Pwdata[31:0]in   write data
//   Prdata[31:0]out  read data, non-zero only on a good read completion
//   Pready      out  transfer complete
//   Pslverr     out  error response, only together with Pready
//   dbg_state_o out  current FSM state (0 = IDLE, 1 = ACCESS)
module apb_slave_regfile #(
    parameter int          SLV_INDEX   = 0,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr,
    output logic        dbg_state_o
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        write_q, write_d;
    logic        err_q, err_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] regs_q [NUM_REGS];

    logic        sel;
    logic [3:0]  idx_in;
    logic        err_in;
    logic        done;
    logic        do_write;
    logic [31:0] rd_val;

    // Upper address bits are decoded by the bridge, other select bits belong
    // to other slaves.
    logic unused_bits;
    assign unused_bits = ^{Paddr[31:6], Pselx & ~(3'b001 << SLV_INDEX)};

    assign sel    = Pselx[SLV_INDEX];
    assign idx_in = Paddr[5:2];
    // Error is decided once at setup so the whole access phase sees a
    // stable answer.
    assign err_in = (Paddr[1:0] != 2'b00) ||
                    ({1'b0, idx_in} >= 5'(NUM_REGS)) ||
                    (Pwrite && (idx_in == 4'd0));

    assign done     = (state_q == S_ACCESS) && sel && (cnt_q == 4'd0);
    assign do_write = done && write_q && !err_q;

    // State register plus latched transfer attributes
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 4'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                // sel with Penable already high is not a valid setup phase
                if (sel && !Penable) begin
                    state_d = S_ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                    idx_d   = idx_in;
                    write_d = Pwrite;
                    err_d   = err_in;
                    wdata_d = Pwdata;
                end
            end
            S_ACCESS: begin
                if (!sel) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register bank; index 0 is never stored, it reads as ID_VALUE
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (do_write && (idx_q == 4'(i))) begin
                    regs_q[i] <= wdata_q;
                end
            end
        end
    end

    // Outputs depend only on registered state, so reset clears them at once
    always_comb begin
        rd_val = 32'd0;
        if (idx_q == 4'd0) begin
            rd_val = ID_VALUE;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (idx_q == 4'(i)) begin
                    rd_val = regs_q[i];
                end
            end
        end
        Pready      = (state_q == S_ACCESS) && (cnt_q == 4'd0);
        Pslverr     = Pready && err_q;
        Prdata      = (Pready && !write_q && !err_q) ? rd_val : 32'd0;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;

    localparam int          NUM_REGS    = 8;
    localparam int          WAIT_CYCLES = 2;
    localparam logic [31:0] ID_VALUE    = 32'hA9B0_0001;

    // ---------------- clock / reset ----------------
    logic        Hclk = 1'b0;
    logic        Hresetn = 1'b0;
    logic [2:0]  Pselx = 3'b000;
    logic        Penable = 1'b0;
    logic        Pwrite = 1'b0;
    logic [31:0] Paddr = 32'd0;
    logic [31:0] Pwdata = 32'd0;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;
    logic        dbg_state;

    always #5 Hclk = ~Hclk;

    apb_slave_regfile #(
        .SLV_INDEX  (0),
        .NUM_REGS   (NUM_REGS),
        .WAIT_CYCLES(WAIT_CYCLES),
        .ID_VALUE   (ID_VALUE)
    ) dut (
        .Hclk       (Hclk),
        .Hresetn    (Hresetn),
        .Pselx      (Pselx),
        .Penable    (Penable),
        .Pwrite     (Pwrite),
        .Paddr      (Paddr),
        .Pwdata     (Pwdata),
        .Prdata     (Prdata),
        .Pready     (Pready),
        .Pslverr    (Pslverr),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [32:0] exp_q[$];          // {pslverr, prdata} per completed transfer
    logic [31:0] model_regs [16];   // reference contents, index 0 unused
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_regs[i] = 32'd0;
    endtask

    // Expected response of a selected transfer, straight from the access rules
    function automatic logic [32:0] model_xfer(input logic wr, input logic [31:0] addr,
                                                input logic [31:0] data);
        int   idx;
        logic err;
        logic [31:0] rd;
        idx = int'(addr[5:2]);
        err = (addr[1:0] != 2'b00) || (idx >= NUM_REGS) || (wr && idx == 0);
        rd  = 32'd0;
        if (!wr && !err) rd = (idx == 0) ? ID_VALUE : model_regs[idx];
        if (wr && !err) model_regs[idx] = data;
        return {err, rd};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge Hclk);
            if (Hresetn) begin
                if (Pready) begin
                    if (exp_q.size() == 0) begin
                        check("ready_without_expected", 64'(Pready), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("completion_resp", 64'({Pslverr, Prdata}), 64'(e));
                    end
                end else begin
                    check("idle_outputs_zero", 64'({Pslverr, Prdata}), 64'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_idle();
        @(negedge Hclk);
        Pselx   = 3'b000;
        Penable = 1'b0;
    endtask

    // mode: 0 normal, 1 drop select in 1st wait cycle,
    //       2 reset in 2nd wait cycle, 3 reset while Pready is high
    task automatic apb_xfer(input logic [2:0] psel, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input int mode);
        int   cycles;
        logic seen;
        @(negedge Hclk);
        Pselx   = psel;
        Penable = 1'b0;
        Pwrite  = wr;
        Paddr   = addr;
        Pwdata  = data;
        if (psel[0] && (mode == 0 || mode == 3)) exp_q.push_back(model_xfer(wr, addr, data));
        @(negedge Hclk);
        Penable = 1'b1;
        Pwdata  = $urandom();   // must not affect the written value
        if (!psel[0]) begin
            seen = 1'b0;
            repeat (WAIT_CYCLES + 3) begin
                if (Pready) seen = 1'b1;
                @(negedge Hclk);
            end
            check("unselected_no_ready", 64'(seen), 64'd0);
            Pselx   = 3'b000;
            Penable = 1'b0;
            return;
        end
        if (mode == 1) begin
            Pselx = 3'b000;
            @(negedge Hclk);
            @(negedge Hclk);
            check("abort_no_ready", 64'({Pready, Prdata}), 64'd0);
            Penable = 1'b0;
            return;
        end
        if (mode == 2) begin
            @(negedge Hclk);
            #2 Hresetn = 1'b0;
            model_reset();
            #1 check("reset_mid_wait_outputs", 64'({Pready, Pslverr, Prdata}), 64'd0);
            @(negedge Hclk);
            Pselx   = 3'b000;
            Penable = 1'b0;
            Hresetn = 1'b1;
            return;
        end
        cycles = 1;
        while (!Pready && cycles < 40) begin
            @(negedge Hclk);
            cycles++;
        end
        check("access_latency", 64'(cycles), 64'(WAIT_CYCLES + 1));
        if (mode == 3) begin
            #2 Hresetn = 1'b0;
            model_reset();
            #1 check("reset_at_ready_outputs", 64'({Pready, Pslverr, Prdata}), 64'd0);
            @(negedge Hclk);
            Pselx   = 3'b000;
            Penable = 1'b0;
            Hresetn = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  psel;
        logic [31:0] addr;
        model_reset();
        #2 check("in_reset_outputs", 64'({Pready, Pslverr, Prdata}), 64'd0);
        repeat (3) @(negedge Hclk);
        Hresetn = 1'b1;
        check("after_reset_outputs", 64'({Pready, Pslverr, Prdata}), 64'd0);

        // Directed scenarios
        apb_xfer(3'b001, 1'b0, 32'h8100_0004, 32'd0, 0);
        apb_xfer(3'b001, 1'b1, 32'h8100_0004, 32'd32, 0);
        apb_xfer(3'b001, 1'b0, 32'h8100_0004, 32'd0, 0);
        apb_xfer(3'b001, 1'b0, 32'h8100_0000, 32'd0, 0);
        apb_xfer(3'b001, 1'b1, 32'h8100_0000, 32'd45, 0);
        apb_xfer(3'b001, 1'b0, 32'h8100_0000, 32'd0, 0);
        bus_idle();
        apb_xfer(3'b001, 1'b1, 32'h8100_0020, 32'hDEAD_BEEF, 0);
        apb_xfer(3'b001, 1'b0, 32'h8100_0006, 32'd0, 0);
        for (int i = 1; i < NUM_REGS; i++) apb_xfer(3'b001, 1'b0, 32'h8100_0000 | 32'(i * 4), 32'd0, 0);
        apb_xfer(3'b010, 1'b1, 32'h8100_0008, 32'd52, 0);
        apb_xfer(3'b001, 1'b0, 32'h8100_0008, 32'd0, 0);

        // sel with Penable high while idle must be ignored
        @(negedge Hclk);
        Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h8100_0010; Pwdata = 32'd77;
        repeat (WAIT_CYCLES + 3) @(negedge Hclk);
        Pselx = 3'b000; Penable = 1'b0;
        apb_xfer(3'b001, 1'b0, 32'h8100_0010, 32'd0, 0);

        // Aborts
        apb_xfer(3'b001, 1'b1, 32'h8100_000C, 32'd543, 1);
        apb_xfer(3'b001, 1'b0, 32'h8100_000C, 32'd0, 0);
        apb_xfer(3'b001, 1'b1, 32'h8100_000C, 32'd543, 2);
        apb_xfer(3'b001, 1'b0, 32'h8100_000C, 32'd0, 0);
        apb_xfer(3'b001, 1'b1, 32'h8100_0014, 32'h1234_5678, 0);
        apb_xfer(3'b001, 1'b0, 32'h8100_0000, 32'd0, 3);
        apb_xfer(3'b001, 1'b0, 32'h8100_0014, 32'd0, 0);

        // Randomized traffic, mixing back-to-back and gapped transfers
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0:       psel = 3'b010;
                1:       psel = 3'b100;
                default: psel = 3'b001;
            endcase
            addr = $urandom();
            addr[5:2] = 4'($urandom_range(0, 15));
            addr[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            apb_xfer(psel, 1'($urandom_range(0, 1)), addr, $urandom(), 0);
            if ($urandom_range(0, 3) == 0) bus_idle();
        end
        bus_idle();

        // Drain, bounded
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge Hclk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge Hclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB responder (completer) at the far end of the AHB-to-APB bridge.
- Decodes one bit of the bridge's one-hot Pselx bus and implements a small 32-bit register bank.
- Inserts a fixed number of wait states, returns read data, and flags bad accesses with Pslverr.
- Serves as the bridge's verification target and as a template for real peripherals.

Parameters:
- SLV_INDEX, 0: which bit of Pselx selects this slave (0..2).
- NUM_REGS, 8: number of 32-bit registers, 2..16. Word index is Paddr[5:2].
- WAIT_CYCLES, 2: access-phase cycles with Pready low before completion (0..15).
- ID_VALUE, 32'hA9B0_0001: constant returned by register 0, which is read-only.

Ports:
- Hclk  in  1  system clock; all state changes on rising edge.
- Hresetn  in  1  asynchronous active-low reset.
- Pselx  in  3  one-hot slave select from the bridge.
- Penable  in  1  APB enable; marks the access phase.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address.
- Pwdata  in  32  write data.
- Prdata  out  32  read data.
- Pready  out  1  transfer-complete indication.
- Pslverr  out  1  error response, valid only while Pready = 1.

Behaviour:
- sel = Pselx[SLV_INDEX]. All other Pselx bits are ignored.
- Reset (Hresetn = 0, asynchronous, immediate):
  - state = IDLE, wait counter = 0.
  - registers 1..NUM_REGS-1 = 0.
  - Prdata = 0, Pready = 0, Pslverr = 0.
- FSM states: IDLE and ACCESS.
- IDLE:
  - If sel = 1 and Penable = 0 at the rising edge (setup phase): latch Paddr, Pwrite and Pwdata, compute err, load counter with WAIT_CYCLES, go to ACCESS.
  - sel = 1 with Penable = 1 while in IDLE is a protocol error: ignore it and stay in IDLE.
- ACCESS, each cycle:
  - If sel = 0: abort to IDLE. No register update; outputs return to 0.
  - Else if counter != 0: decrement the counter. Pready = 0.
  - Else (counter = 0): Pready = 1. At this edge, if the latched access is a write with err = 0, update the register. Go to IDLE.
- Pready is decoded as (state == ACCESS && counter == 0), giving WAIT_CYCLES + 1 access-phase cycles.
  - With WAIT_CYCLES = 0, the transfer completes in the first access cycle.
- err = 1 when any of the following holds:
  - latched Paddr[1:0] != 0 (misaligned);
  - word index >= NUM_REGS;
  - write to index 0.
- Pslverr = err && Pready. It is 0 at all other times.
- Errored writes never change any register. Errored reads return Prdata = 0.
- Prdata:
  - Carries the selected register only while Pready = 1 and the latched Pwrite = 0.
  - Index 0 returns ID_VALUE.
  - Prdata = 0 at all other times, including during writes and wait cycles.
- Paddr[31:6] is not decoded; the bridge performs base-address selection via Pselx.
- Back-to-back transfers:
  - After completion the FSM is in IDLE for the next cycle, which is the bridge's next setup phase.
  - No idle bubble beyond APB's mandatory setup cycle.
- Reset asserted mid-ACCESS:
  - Aborts immediately with no write.
  - Outputs drop to 0 without waiting for a clock edge.
- The latched write data is used, so Pwdata changes after setup do not affect the written value.

Test Plan:
Defaults for all scenarios: SLV_INDEX = 0, NUM_REGS = 8, WAIT_CYCLES = 2.
1. Reset, then read 0x8100_0004 -> Pready low for 2 access cycles and high on the 3rd; Prdata = 0, Pslverr = 0.
2. Write 0x8100_0004 with data 32'd32, then read it back -> write completes on the 3rd access cycle; read returns 32'h0000_0020.
3. Read 0x8100_0000 -> Prdata = 32'hA9B0_0001. Write 32'd45 to 0x8100_0000 -> Pslverr = 1 with Pready; a subsequent read still returns ID_VALUE.
4. Write to 0x8100_0020 (index 8) and read from 0x8100_0006 (misaligned) -> Pslverr = 1 and Prdata = 0 on both; registers 1..7 are unchanged.
5. Pselx = 3'b010 with a write of 32'd52 to 0x8100_0008 -> Pready stays 0; reading index 2 with Pselx = 3'b001 returns 0.
6. Write 32'd543 to 0x8100_000C, then either drop sel in the 1st wait cycle or pulse Hresetn low in the 2nd wait cycle -> FSM returns to IDLE, index 3 stays 0, and Pready/Prdata go to 0 immediately on reset.
